// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'b00,
        ArbData = 2'b01,
        ArbInst = 2'b10,
        ArbDone = 2'b11
    } arb_state_t;

    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [3:0]  SelAll       = 4'b1111;

endpackage

// File: rtl/mem_arbiter.sv
// Sequences each pipeline beat onto one memory bus: data access first, then
// instruction fetch; stalls the pipeline until the beat completes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_ce_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_sel_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o,
    output logic        stallreq_o
);

    localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

    arb_state_t  r_state;
    arb_state_t  w_next;
    logic        r_inst_flag;
    logic [31:0] r_inst_addr;
    logic [7:0]  r_cnt;
    logic        r_err;
    logic        w_timeout;
    logic        w_xfer_end;
    logic [31:0] w_rdata;

    // A timeout is the cycle the counter would reach ACK_TIMEOUT; it acts as an ack.
    assign w_timeout  = ~bus_ack_i & (r_cnt == TimeoutLast);
    assign w_xfer_end = bus_ack_i | w_timeout;
    assign w_rdata    = w_timeout ? ZeroWord : bus_rdata_i;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ArbIdle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ArbIdle: if (data_ce_i | inst_ce_i) w_next = data_ce_i ? ArbData : ArbInst;
            ArbData: if (w_xfer_end) w_next = r_inst_flag ? ArbInst : ArbDone;
            ArbInst: if (w_xfer_end) w_next = ArbDone;
            default: w_next = ArbIdle;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        case (r_state)
            ArbIdle: stallreq_o = data_ce_i | inst_ce_i;
            ArbData,
            ArbInst: stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
    end

    // Bus outputs, request latches, timeout counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_flag  <= 1'b0;
            r_inst_addr  <= ZeroWord;
            r_cnt        <= 8'd0;
            r_err        <= 1'b0;
            bus_ce_o     <= ChipDisable;
            bus_we_o     <= WriteDisable;
            bus_addr_o   <= ZeroWord;
            bus_sel_o    <= 4'b0000;
            bus_wdata_o  <= ZeroWord;
            bus_err_o    <= 1'b0;
            inst_data_o  <= ZeroWord;
            data_rdata_o <= ZeroWord;
        end else begin
            case (r_state)
                ArbIdle: begin
                    bus_err_o <= 1'b0;
                    if (data_ce_i | inst_ce_i) begin
                        r_inst_flag <= inst_ce_i;
                        r_inst_addr <= inst_addr_i;
                        r_cnt       <= 8'd0;
                        r_err       <= 1'b0;
                        bus_ce_o    <= ChipEnable;
                        if (data_ce_i) begin
                            bus_we_o    <= data_we_i;
                            bus_addr_o  <= data_addr_i;
                            bus_sel_o   <= data_sel_i;
                            bus_wdata_o <= data_wdata_i;
                        end else begin
                            bus_we_o    <= WriteDisable;
                            bus_addr_o  <= inst_addr_i;
                            bus_sel_o   <= SelAll;
                            bus_wdata_o <= ZeroWord;
                        end
                    end
                end
                ArbData: begin
                    if (w_xfer_end) begin
                        if (bus_we_o == WriteDisable) data_rdata_o <= w_rdata;
                        r_err <= r_err | w_timeout;
                        r_cnt <= 8'd0;
                        if (r_inst_flag) begin
                            bus_ce_o    <= ChipEnable;
                            bus_we_o    <= WriteDisable;
                            bus_addr_o  <= r_inst_addr;
                            bus_sel_o   <= SelAll;
                            bus_wdata_o <= ZeroWord;
                        end else begin
                            bus_ce_o    <= ChipDisable;
                            bus_we_o    <= WriteDisable;
                            bus_addr_o  <= ZeroWord;
                            bus_sel_o   <= 4'b0000;
                            bus_wdata_o <= ZeroWord;
                            bus_err_o   <= r_err | w_timeout;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ArbInst: begin
                    if (w_xfer_end) begin
                        inst_data_o <= w_rdata;
                        r_err       <= r_err | w_timeout;
                        r_cnt       <= 8'd0;
                        bus_ce_o    <= ChipDisable;
                        bus_we_o    <= WriteDisable;
                        bus_addr_o  <= ZeroWord;
                        bus_sel_o   <= 4'b0000;
                        bus_wdata_o <= ZeroWord;
                        bus_err_o   <= r_err | w_timeout;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    bus_err_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;
    logic        bus_err_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_errors = 0;

    mem_arbiter #(.ACK_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_ce_i    (inst_ce_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_addr_i  (data_addr_i),
        .data_sel_i   (data_sel_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .bus_ce_o     (bus_ce_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_sel_o    (bus_sel_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rdata_i  (bus_rdata_i),
        .bus_ack_i    (bus_ack_i),
        .bus_err_o    (bus_err_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cnt;
        int ce_cnt;

        rst = 1'b1; inst_ce_i = 1'b0; inst_addr_i = '0; data_ce_i = 1'b0;
        data_we_i = 1'b0; data_addr_i = '0; data_sel_i = '0; data_wdata_i = '0;
        bus_rdata_i = '0; bus_ack_i = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_bus_ce", 32'(bus_ce_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'h0);
        chk("rst_inst_data", inst_data_o, 32'h0);
        chk("rst_data_rdata", data_rdata_o, 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);

        // Fetch only, ack in first cycle
        inst_ce_i = 1'b1; inst_addr_i = 32'h100;
        #1 chk("f_stall_idle", 32'(stallreq_o), 32'd1);
        step();
        chk("f_bus_ce", 32'(bus_ce_o), 32'd1);
        chk("f_bus_addr", bus_addr_o, 32'h100);
        chk("f_bus_we", 32'(bus_we_o), 32'd0);
        chk("f_bus_sel", 32'(bus_sel_o), 32'hF);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3C010001;
        step();
        bus_ack_i = 1'b0; inst_ce_i = 1'b0; bus_rdata_i = '0;
        #1;
        chk("f_inst_data", inst_data_o, 32'h3C010001);
        chk("f_stall_done", 32'(stallreq_o), 32'd0);
        chk("f_bus_ce_done", 32'(bus_ce_o), 32'd0);
        step();

        // Simultaneous load 0x200 and fetch 0x104, acks in 2nd cycle of each
        stall_cnt = 0;
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h200; data_sel_i = 4'hF;
        inst_ce_i = 1'b1; inst_addr_i = 32'h104;
        #1 stall_cnt += int'(stallreq_o);
        step(); stall_cnt += int'(stallreq_o);
        chk("b_addr_d1", bus_addr_o, 32'h200);
        step(); stall_cnt += int'(stallreq_o);
        chk("b_addr_d2", bus_addr_o, 32'h200);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h11223344;
        step(); bus_ack_i = 1'b0; bus_rdata_i = '0;
        #1 stall_cnt += int'(stallreq_o);
        chk("b_addr_i1", bus_addr_o, 32'h104);
        chk("b_sel_i1", 32'(bus_sel_o), 32'hF);
        chk("b_data_early", data_rdata_o, 32'h11223344);
        step(); stall_cnt += int'(stallreq_o);
        chk("b_addr_i2", bus_addr_o, 32'h104);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h55667788;
        step(); bus_ack_i = 1'b0; bus_rdata_i = '0; data_ce_i = 1'b0; inst_ce_i = 1'b0;
        #1;
        chk("b_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("b_stall_done", 32'(stallreq_o), 32'd0);
        chk("b_inst_data", inst_data_o, 32'h55667788);
        chk("b_data_rdata", data_rdata_o, 32'h11223344);
        chk("b_bus_ce_done", 32'(bus_ce_o), 32'd0);
        step();

        // Store with one byte lane
        data_ce_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h300;
        data_sel_i = 4'b0100; data_wdata_i = 32'hABABABAB;
        step();
        chk("s_bus_we", 32'(bus_we_o), 32'd1);
        chk("s_bus_sel", 32'(bus_sel_o), 32'h4);
        chk("s_bus_wdata", bus_wdata_o, 32'hABABABAB);
        chk("s_bus_addr", bus_addr_o, 32'h300);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
        step(); bus_ack_i = 1'b0; bus_rdata_i = '0; data_ce_i = 1'b0; data_we_i = 1'b0;
        #1;
        chk("s_rdata_kept", data_rdata_o, 32'h11223344);
        chk("s_bus_ce_done", 32'(bus_ce_o), 32'd0);
        step();

        // Load with no ack: times out after 4 cycles
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h400; data_sel_i = 4'hF;
        step(); data_ce_i = 1'b0;
        ce_cnt = 0;
        for (int i = 0; i < 12 && bus_ce_o; i++) begin
            ce_cnt++;
            step();
        end
        chk("t_ce_cycles", 32'(ce_cnt), 32'd4);
        chk("t_err_pulse", 32'(bus_err_o), 32'd1);
        chk("t_rdata_zero", data_rdata_o, 32'h0);
        chk("t_stall_done", 32'(stallreq_o), 32'd0);
        step();
        chk("t_err_cleared", 32'(bus_err_o), 32'd0);

        // Reset in the 2nd DATA cycle; a late ack must not capture
        data_ce_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h500; data_sel_i = 4'hF;
        step(); data_ce_i = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        chk("r_bus_ce", 32'(bus_ce_o), 32'd0);
        chk("r_bus_addr", bus_addr_o, 32'h0);
        chk("r_inst_data", inst_data_o, 32'h0);
        chk("r_stall", 32'(stallreq_o), 32'd0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h99999999;
        step(); bus_ack_i = 1'b0; bus_rdata_i = '0;
        chk("r_no_capture", data_rdata_o, 32'h0);
        chk("r_bus_ce_late", 32'(bus_ce_o), 32'd0);

        // Recovery: fetch proceeds normally from IDLE
        inst_ce_i = 1'b1; inst_addr_i = 32'h108;
        step();
        chk("r_fetch_addr", bus_addr_o, 32'h108);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h24420004;
        step(); bus_ack_i = 1'b0; bus_rdata_i = '0; inst_ce_i = 1'b0;
        chk("r_fetch_data", inst_data_o, 32'h24420004);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
